// File: rtl/tiny_riscv_uart_rx_periph_if.sv
// Processor-side bus for the UART receive peripheral: decode selects,
// read/write strobes, registered read data and the data-available flag.
interface tiny_riscv_uart_rx_periph_if;
  logic        i_data_sel;
  logic        i_status_sel;
  logic        i_read_strobe;
  logic        i_write_strobe;
  logic [31:0] o_read_data;
  logic        o_rx_avail;

  modport master (
    output i_data_sel, i_status_sel, i_read_strobe, i_write_strobe,
    input  o_read_data, o_rx_avail
  );

  modport slave (
    input  i_data_sel, i_status_sel, i_read_strobe, i_write_strobe,
    output o_read_data, o_rx_avail
  );
endinterface

// File: rtl/tiny_riscv_uart_rx_periph.sv
// UART receiver peripheral: 2-flop input synchronizer, frame FSM, receive
// FIFO and a memory-mapped data/status read port with sticky error flags.
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// after the data bits; otherwise frames are 8N1 and parity_err reads 0.
module tiny_riscv_uart_rx_periph #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic i_Clk,
  input  logic i_Rst_N,
  input  logic i_UART_RX,
  tiny_riscv_uart_rx_periph_if.slave bus
);

  localparam int CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]      FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]      HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE = PTR_W'(1);
  localparam logic [FIFO_CNT_W-1:0] OCC_ONE = FIFO_CNT_W'(1);
  localparam logic [FIFO_CNT_W-1:0] DEPTH_C = FIFO_CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif

  logic             rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_req, frame_err_set, parity_err_bit;

  logic [7:0]            fifo_mem_q [FIFO_DEPTH];
  logic [7:0]            fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] occ_q, occ_d;
  logic                  frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic [31:0]           read_data_q, read_data_d;
  logic                  data_rd, status_rd, status_clr, fifo_empty, fifo_full;
  logic                  pop, push_ok, overrun_set;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, parity_err_q, parity_err_d, parity_err_set;
`endif

  // Bring the asynchronous serial line into the clock domain
  always_comb begin
    rx_meta_d = i_UART_RX;
    rx_sync_d = rx_meta_q;
  end

  // Frame FSM: centre-samples each bit and requests a push on a good stop bit
  always_comb begin
    state_d       = state_q;
    clk_cnt_d     = clk_cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    push_req      = 1'b0;
    frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d      = par_bad_q;
    parity_err_set = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_sync_q) state_d = ST_START;
      end
      ST_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          state_d   = rx_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          state_d   = ST_STOP;
          if ((^shift_q) != rx_sync_q) begin
            par_bad_d      = 1'b1;
            parity_err_set = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          state_d   = ST_IDLE;
          if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
            push_req = !par_bad_q;
`else
            push_req = 1'b1;
`endif
          end else begin
            frame_err_set = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus decode, FIFO bookkeeping, sticky flags and registered read data
  always_comb begin
    data_rd     = bus.i_read_strobe & bus.i_data_sel;
    status_rd   = bus.i_read_strobe & bus.i_status_sel & !bus.i_data_sel;
    status_clr  = bus.i_write_strobe & !bus.i_read_strobe & bus.i_status_sel;
    fifo_empty  = (occ_q == '0);
    fifo_full   = (occ_q == DEPTH_C);
    pop         = data_rd & !fifo_empty;
    push_ok     = push_req & (!fifo_full | pop);
    overrun_set = push_req & fifo_full & !pop;

    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    if (push_ok) begin
      fifo_mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d             = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop)      occ_d = occ_q + OCC_ONE;
    else if (pop && !push_ok) occ_d = occ_q - OCC_ONE;

    frame_err_d = (frame_err_q & !status_clr) | frame_err_set;
    overrun_d   = (overrun_q & !status_clr) | overrun_set;
`ifdef UART_RX_PARITY_EN
    parity_err_d   = (parity_err_q & !status_clr) | parity_err_set;
    parity_err_bit = parity_err_q;
`else
    parity_err_bit = 1'b0;
`endif

    read_data_d = '0;
    if (data_rd) begin
      if (!fifo_empty) read_data_d = {23'b0, 1'b1, fifo_mem_q[rd_ptr_q]};
    end else if (status_rd) begin
      read_data_d = {16'b0, 8'(occ_q), 5'b0, parity_err_bit, overrun_q, frame_err_q};
    end
  end

  // Single clocked process for all state, with synchronous active-low reset
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      read_data_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      read_data_q <= read_data_d;
      fifo_mem_q  <= fifo_mem_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.o_read_data = read_data_q;
  assign bus.o_rx_avail  = (occ_q != '0);

endmodule

// File: tb/tb_tiny_riscv_uart_rx_periph.sv
// Scoreboard bench for tiny_riscv_uart_rx_periph: bus operations push their
// expected {read_data, rx_avail} response; a monitor pops and compares it
// on the cycle after each strobe.
module tb_tiny_riscv_uart_rx_periph;
  localparam int CLKS  = 217;
  localparam int DEPTH = 8;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic uart_rx = 1'b1;

  tiny_riscv_uart_rx_periph_if bus ();

  tiny_riscv_uart_rx_periph #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clk     (clk),
    .i_Rst_N   (rst_n),
    .i_UART_RX (uart_rx),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [32:0] exp_q [$];
  string       name_q [$];
  int          pass_count  = 0;
  int          check_count = 0;
  logic        bus_seen    = 1'b0;
  logic [32:0] mon_exp;
  string       mon_name;

  // Remember whether a bus strobe was presented at this edge
  always @(posedge clk) bus_seen <= bus.i_read_strobe | bus.i_write_strobe;

  // Monitor: compare the response that follows every strobe
  always @(negedge clk) begin
    if (bus_seen) begin
      check_count++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_response: got data=%h avail=%b, none expected",
                 bus.o_read_data, bus.o_rx_avail);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if ({bus.o_read_data, bus.o_rx_avail} === mon_exp)
          pass_count++;
        else
          $display("[TB] FAIL %s: got data=%h avail=%b, expected data=%h avail=%b",
                   mon_name, bus.o_read_data, bus.o_rx_avail, mon_exp[32:1], mon_exp[0]);
      end
    end
  end

  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic dsel, input logic ssel,
                               input logic [31:0] exp_data, input logic exp_avail);
    @(negedge clk);
    bus.i_read_strobe  = rd;
    bus.i_write_strobe = wr;
    bus.i_data_sel     = dsel;
    bus.i_status_sel   = ssel;
    exp_q.push_back({exp_data, exp_avail});
    name_q.push_back(name);
    @(negedge clk);
    bus.i_read_strobe  = 1'b0;
    bus.i_write_strobe = 1'b0;
    bus.i_data_sel     = 1'b0;
    bus.i_status_sel   = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [32:0] actual,
                             input logic [32:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic idle_bits(input int n);
    uart_rx = 1'b1;
    repeat (n * CLKS) @(negedge clk);
  endtask

  task automatic uart_send(input logic [7:0] b, input bit par_flip, input bit bad_stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLKS) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = (^b) ^ par_flip;
    repeat (CLKS) @(negedge clk);
`else
    if (par_flip) $display("[TB] parity override ignored in 8N1 build");
`endif
    if (bad_stop) begin
      uart_rx = 1'b0;
      repeat (CLKS * 3 / 4) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CLKS - CLKS * 3 / 4) @(negedge clk);
    end else begin
      uart_rx = 1'b1;
      repeat (CLKS) @(negedge clk);
    end
    idle_bits(1);
  endtask

  initial begin
    bus.i_read_strobe  = 1'b0;
    bus.i_write_strobe = 1'b0;
    bus.i_data_sel     = 1'b0;
    bus.i_status_sel   = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    checkOutput("reset_outputs", {bus.o_read_data, bus.o_rx_avail}, 33'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus("reset_status", 1, 0, 0, 1, 32'h0, 1'b0);

    // Single frame 0x41, then read it out
    uart_send(8'h41, 1'b0, 1'b0);
    applyStimulus("a41_status", 1, 0, 0, 1, 32'h0000_0100, 1'b1);
    applyStimulus("unselected_read", 1, 0, 0, 0, 32'h0, 1'b1);
    applyStimulus("write_data_sel", 0, 1, 1, 0, 32'h0, 1'b1);
    applyStimulus("a41_data", 1, 0, 1, 0, 32'h0000_0141, 1'b0);
    applyStimulus("empty_data_read", 1, 0, 1, 0, 32'h0, 1'b0);

    // Nine frames into an 8-deep FIFO: overrun, first eight kept
    for (int i = 0; i < 9; i++) uart_send(8'(i), 1'b0, 1'b0);
    applyStimulus("full_status", 1, 0, 0, 1, 32'h0000_0802, 1'b1);
    for (int i = 0; i < 8; i++)
      applyStimulus($sformatf("drain_%0d", i), 1, 0, 1, 0, 32'h100 + 32'(i), (i < 7));
    applyStimulus("rw_status_is_read", 1, 1, 0, 1, 32'h0000_0002, 1'b0);
    applyStimulus("overrun_kept", 1, 0, 0, 1, 32'h0000_0002, 1'b0);
    applyStimulus("status_clear", 0, 1, 0, 1, 32'h0, 1'b0);
    applyStimulus("cleared_status", 1, 0, 0, 1, 32'h0, 1'b0);

    // Stop bit held low: frame error, byte dropped
    uart_send(8'h55, 1'b0, 1'b1);
    applyStimulus("frame_err_status", 1, 0, 0, 1, 32'h0000_0001, 1'b0);
    applyStimulus("frame_err_clear", 0, 1, 0, 1, 32'h0, 1'b0);
    applyStimulus("frame_err_cleared", 1, 0, 0, 1, 32'h0, 1'b0);

    // 50-cycle glitch on the line
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (50) @(negedge clk);
    idle_bits(2);
    applyStimulus("glitch_status", 1, 0, 0, 1, 32'h0, 1'b0);

    // Reset during bit 4 of a frame with a byte already queued
    uart_send(8'h11, 1'b0, 1'b0);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = 1'b1;
      repeat (CLKS) @(negedge clk);
    end
    uart_rx = 1'b0;
    repeat (CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid_frame_reset", {bus.o_read_data, bus.o_rx_avail}, 33'h0);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    uart_send(8'h5A, 1'b0, 1'b0);
    applyStimulus("after_reset_status", 1, 0, 0, 1, 32'h0000_0100, 1'b1);
    applyStimulus("after_reset_data", 1, 0, 1, 0, 32'h0000_015A, 1'b0);

`ifdef UART_RX_PARITY_EN
    // Even parity: wrong bit sets parity_err and drops, right bit keeps byte
    uart_send(8'h03, 1'b1, 1'b0);
    applyStimulus("parity_bad_status", 1, 0, 0, 1, 32'h0000_0004, 1'b0);
    applyStimulus("parity_clear", 0, 1, 0, 1, 32'h0, 1'b0);
    uart_send(8'h03, 1'b0, 1'b0);
    applyStimulus("parity_good_status", 1, 0, 0, 1, 32'h0000_0100, 1'b1);
    applyStimulus("parity_good_data", 1, 0, 1, 0, 32'h0000_0103, 1'b0);
`endif

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      check_count++;
      $display("[TB] FAIL unanswered_ops: got %0d pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule

// File: doc/tiny_riscv_uart_rx_periph.md
TINY_RISCV_UART_RX_PERIPH -- requirements
Module: tiny_riscv_uart_rx_periph

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, i_Clk cycles per UART bit.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of 2, minimum 2).
REQ-003 SHALL have port i_Clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_UART_RX  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port i_data_sel  input  1  peripheral decode selects the RX data word.
REQ-007 SHALL have port i_status_sel  input  1  peripheral decode selects the RX status word.
REQ-008 SHALL have port i_read_strobe  input  1  processor read request.
REQ-009 SHALL have port i_write_strobe  input  1  processor write request (any write-mask bit set).
REQ-010 SHALL have port o_read_data  output  32  registered read data to the processor read mux.
REQ-011 SHALL have port o_rx_avail  output  1  high while the FIFO is non-empty.

Function
REQ-012 SHALL pass i_UART_RX through a 2-flop synchronizer before any use; the synchronizer resets to 1.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY per REQ-029).
REQ-014 IDLE -> START on synchronized line = 0; bit counter cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles, sample; 0 -> DATA, 1 -> IDLE (glitch, nothing recorded).
REQ-016 DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first; after bit 7 -> STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, sample; 1 -> push byte; 0 -> set sticky frame_err, drop byte; either way -> IDLE.
REQ-018 Push into a full FIFO SHALL drop the byte and set sticky overrun, unless a pop occurs the same cycle, in which case the push is accepted.
REQ-019 Data read (i_read_strobe & i_data_sel) with FIFO non-empty SHALL return {23'b0, 1'b1, head_byte} on o_read_data the next cycle and pop the head at that edge.
REQ-020 Data read with FIFO empty SHALL return 32'h0000_0000 and not change FIFO state.
REQ-021 Status read SHALL return next cycle {16'b0, count[7:0], 5'b0, parity_err, overrun, frame_err}; count = FIFO occupancy 0..FIFO_DEPTH.
REQ-022 Write with i_status_sel SHALL clear all sticky error flags at that edge; a flag set in the same cycle SHALL win (remain set).
REQ-023 o_read_data SHALL be 0 in any cycle following a non-read or unselected read.
REQ-024 Read and write strobes asserted together SHALL be treated as a read only.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL never exceed FIFO_DEPTH.
REQ-026 o_rx_avail SHALL be combinational from occupancy != 0.

Reset
REQ-027 On i_Rst_N = 0 at a clock edge: FSM -> IDLE, counters 0, FIFO empty, all flags 0, o_read_data = 0, o_rx_avail = 0.
REQ-028 Reset mid-frame SHALL abandon the partial byte; reception resumes at the next falling edge after reset release.

Configuration
REQ-029 With UART_RX_PARITY_EN defined, a PARITY state SHALL follow DATA, sampling one even-parity bit; mismatch sets sticky parity_err and drops the byte; STOP handling unchanged.
REQ-030 Without UART_RX_PARITY_EN, no PARITY state exists, frames are 8N1, and parity_err reads 0.

Verification
REQ-031 Frame 0x41 8N1 at 217 clks/bit, then data read -> o_read_data = 32'h0000_0141, o_rx_avail falls after the pop.
REQ-032 9 frames 0x00..0x08 with no reads (depth 8) -> status count = 8, overrun = 1; 8 data reads return 0x100..0x107.
REQ-033 Frame with stop bit held 0 -> frame_err = 1, count = 0; status write then status read -> 32'h0.
REQ-034 Low pulse of 50 cycles on i_UART_RX -> FSM back to IDLE, count = 0, no flags set.
REQ-035 Reset asserted during bit 4 of a frame, then frame 0x5A -> single entry 0x15A, no flags.
REQ-036 With UART_RX_PARITY_EN: 0x03 with parity bit 1 -> parity_err = 1, count = 0; with parity bit 0 -> entry 0x103.
